// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and mem_responder.
// The master drives the request side; the slave answers with ack/rdata/err.
interface mem_responder_if;
    logic        req;
    logic        we;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack;
    logic        busy;
    logic        err;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack, busy, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// Wait-state memory responder: IDLE -> WAIT x WAIT_CYCLES -> RESP (ack).
// Optional MEM_BOUNDS_CHECK_EN flags addr >= DEPTH with err instead of aliasing.
module mem_responder #(
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [11:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        ack_q;
    logic [15:0] mem_q [DEPTH];

    logic          go_resp;
    logic          c_we;
    logic [11:0]   c_addr;
    logic [15:0]   c_wdata;
    logic [AW-1:0] idx;
    logic          in_range;

    // Commit uses live inputs when jumping straight from IDLE to RESP.
    always_comb begin
        go_resp = 1'b0;
        c_we    = we_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    c_we    = bus.we;
                    c_addr  = bus.addr;
                    c_wdata = bus.wdata;
                    go_resp = (WAIT_CYCLES == 0);
                end
            end
            WAIT:    go_resp = (cnt_q == 4'd1);
            default: go_resp = 1'b0;
        endcase
    end

    assign idx = c_addr[AW-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
    logic err_q;

    assign in_range = ({1'b0, c_addr} < 13'(DEPTH));
    assign bus.err  = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= go_resp & ~in_range;
        end
    end
`else
    assign in_range = 1'b1;
    assign bus.err  = 1'b0;
`endif

    // Array is never reset; a reset edge also blocks a pending commit.
    always_ff @(posedge clk) begin
        if (go_resp && !rst && c_we && in_range) begin
            mem_q[idx] <= c_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 12'h000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        we_q    <= bus.we;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            if (go_resp) begin
                state_q <= RESP;
                ack_q   <= 1'b1;
                if (!c_we) begin
                    rdata_q <= in_range ? mem_q[idx] : 16'h0000;
                end
            end
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;
    assign bus.busy  = (state_q != IDLE);
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, meaning the number of 16-bit words stored; legal values are powers of 2 from 16 to 4096.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states inserted before each response; legal range is 0..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req, input, 1 bit: the initiator's request strobe.
REQ-006 SHALL have port we, input, 1 bit: 1 = write, 0 = read; sampled with req.
REQ-007 SHALL have port addr, input, 12 bits: the word address; sampled with req.
REQ-008 SHALL have port wdata, input, 16 bits: the write data; sampled with req.
REQ-009 SHALL have port rdata, output, 16 bits: read data, registered.
REQ-010 SHALL have port ack, output, 1 bit: a one-cycle completion pulse.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-012 SHALL have port err, output, 1 bit: an out-of-range flag, valid only while ack is high.

Function
REQ-013 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-014 SHALL, in IDLE with req=1 at a rising edge, latch we, addr and wdata, load the wait counter with WAIT_CYCLES, and enter WAIT; if WAIT_CYCLES=0, it SHALL enter RESP directly.
REQ-015 SHALL, in WAIT, decrement the counter each cycle and enter RESP on the edge where the counter goes from 1 to 0.
REQ-016 SHALL commit a write to the array, or load rdata from the array for a read, on the edge that enters RESP.
REQ-017 SHALL assert ack for exactly the one cycle spent in RESP, then return to IDLE unconditionally.
REQ-018 SHALL make the latency WAIT_CYCLES+1 cycles from the req-sampling edge to ack high.
REQ-019 SHALL make minimum throughput one transaction per WAIT_CYCLES+2 cycles.
REQ-020 SHALL ignore req, we, addr and wdata while busy=1; the latched values alone govern the transaction.
REQ-021 SHALL treat req held high through RESP as a new request, sampled in the following IDLE cycle.
REQ-022 SHALL hold rdata stable until the next read completes; writes SHALL NOT alter rdata.
REQ-023 SHALL keep busy combinational from state: high in WAIT and RESP, low in IDLE.

Reset
REQ-024 SHALL, on rst=1, immediately force state=IDLE, counter=0, rdata=16'h0000, ack=0, busy=0 and err=0.
REQ-025 SHALL make reset mid-transaction abort it: a write not yet in RESP is never committed, and no ack is issued.
REQ-026 SHALL NOT clear array contents on reset.

Configuration
REQ-027 SHALL recognise the macro MEM_BOUNDS_CHECK_EN.
REQ-028 SHALL, with MEM_BOUNDS_CHECK_EN defined, treat a latched addr >= DEPTH as follows in RESP: suppress the write, load rdata=16'h0000 for a read, and assert err=1 with ack.
REQ-029 SHALL, with MEM_BOUNDS_CHECK_EN undefined, index the array with addr modulo DEPTH (low log2(DEPTH) bits) and tie err constantly to 0.

Verification
REQ-030 SHALL cover basic access: reset, write addr=0x005 data=0xBEEF, then read 0x005 -> each ack 3 cycles after req (WAIT_CYCLES=2), rdata=0xBEEF.
REQ-031 SHALL cover zero wait: WAIT_CYCLES=0, req read -> ack on the next cycle; back-to-back reads complete every 2 cycles.
REQ-032 SHALL cover a busy-period request: pulse req with write addr=0x007 data=0x1111 while busy -> ignored; a read of 0x007 returns the prior contents.
REQ-033 SHALL cover reset mid-write: assert rst during WAIT of write 0x010=0xAAAA -> no ack, busy=0; a later read of 0x010 returns the old value.
REQ-034 SHALL cover out-of-range access: DEPTH=16, write 0x013=0x1234 -> with the macro, err=1 with ack and 0x003 unchanged; without the macro, err=0 and a read of 0x003 returns 0x1234.
REQ-035 SHALL cover held req: keep req=1 continuously with WAIT_CYCLES=1 -> ack pulses every 3 cycles, each exactly 1 cycle wide.
